// File: rtl/follow_mon_pkg.sv
// Shared types and limits for the follower-stage monitor.
package follow_mon_pkg;

  localparam int MAX_LATENCY = 16;
  localparam int HIST_W      = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

endpackage : follow_mon_pkg

// File: rtl/follow_mon_dly.sv
// LATENCY-deep shift register of the monitored input; tap is the value
// LATENCY shift cycles ago. Flush has priority over shift.
module follow_mon_dly #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic flush,
  input  logic din,
  output logic tap
);

  logic [LATENCY-1:0] dly_q;
  logic [LATENCY-1:0] dly_d;

  // Next contents: cleared on flush, shifted by one on enabled cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    dly_d = dly_q;
    if (flush) begin
      dly_d = '0;
    end else if (shift_en) begin
      dly_d[0] = din;
      for (int i = 1; i < LATENCY; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  // Delay line register.
  always_ff @(posedge clk) begin
    // NOTE: this data-path storage is reset because a known-zero history is part of the observable behaviour.
    if (!reset) dly_q <= '0;
    else        dly_q <= dly_d;
  end

  assign tap = dly_q[LATENCY-1];

endmodule : follow_mon_dly

// File: rtl/follow_monitor.sv
// Monitor for a registered follower stage: flags every cycle where out_sig
// differs from in_sig delayed by LATENCY enabled cycles, keeps a sticky fail
// state and a saturating mismatch count.
// Optional feature macro: FOLLOW_MON_FIRST_FAIL_EN adds first_fail_cyc.
module follow_monitor
  import follow_mon_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_sig,
  input  logic             out_sig,
  output logic             fail,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [1:0]       state
`ifdef FOLLOW_MON_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] first_fail_cyc
`endif
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("follow_monitor: LATENCY must be within 1..MAX_LATENCY");
  end

  localparam logic [HIST_W-1:0] LAT_H   = HIST_W'(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [HIST_W-1:0]  hist_q, hist_d, hist_inc;
  logic               fail_q, fail_d;
  logic               fail_sticky_q, fail_sticky_d;
  logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic               tap;
  logic               mismatch;
  logic               flush;

  follow_mon_dly #(.LATENCY(LATENCY)) u_dly (
    .clk      (clk),
    .reset    (reset),
    .shift_en (enable),
    .flush    (flush),
    .din      (in_sig),
    .tap      (tap)
  );

  // Comparator, FSM next state, history count and counters.
  always_comb begin
    hist_inc = (enable && hist_q != LAT_H) ? hist_q + HIST_W'(1) : hist_q;
    mismatch = ((state_q == S_CHECK) || (state_q == S_FAIL && enable)) && (out_sig != tap);

    state_d = state_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (enable) state_d = (hist_inc == LAT_H) ? S_CHECK : S_FILL;
        else        state_d = S_IDLE;
      end
      S_CHECK: begin
        if (mismatch)     state_d = S_FAIL;
        else if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_FAIL;
    endcase
    if (clear) state_d = S_IDLE;

    // Returning to idle discards all history.
    flush         = (state_d == S_IDLE);
    hist_d        = flush ? '0 : hist_inc;
    fail_d        = mismatch && !clear;
    fail_sticky_d = (state_d == S_FAIL);

    if (clear)                                   mismatch_cnt_d = '0;
    else if (mismatch && mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
    else                                         mismatch_cnt_d = mismatch_cnt_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q        <= S_IDLE;
      hist_q         <= '0;
      fail_q         <= 1'b0;
      fail_sticky_q  <= 1'b0;
      mismatch_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      fail_q         <= fail_d;
      fail_sticky_q  <= fail_sticky_d;
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

  assign fail         = fail_q;
  assign fail_sticky  = fail_sticky_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign state        = state_q;

`ifdef FOLLOW_MON_FIRST_FAIL_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;

  // Enabled-cycle index since the last idle exit; capture it on the first mismatch.
  always_comb begin
    if (flush)                             cyc_d = '0;
    else if (enable && cyc_q != CNT_MAX)   cyc_d = cyc_q + CNT_W'(1);
    else                                   cyc_d = cyc_q;

    if (clear)                                    first_fail_d = '0;
    else if (mismatch && mismatch_cnt_q == '0)    first_fail_d = cyc_q;
    else                                          first_fail_d = first_fail_q;
  end

  // Cycle index and first-fail registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q        <= '0;
      first_fail_q <= '0;
    end else begin
      cyc_q        <= cyc_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign first_fail_cyc = first_fail_q;
`endif

endmodule : follow_monitor

// File: tb/tb_follow_monitor.sv
// Self-checking bench: three monitor instances (LATENCY/CNT_W = 1/8, 3/8, 5/3)
// share enable/clear/in_sig, each gets its own out_sig. A behavioural model
// tracks enabled-cycle history as plain bit vectors and counts.
module tb_follow_monitor;

  localparam int NI = 3;

  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int w_of(int k);
    return (k == 2) ? 3 : 8;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, enable, clear, in_sig;
  logic [NI-1:0]  out_v;
  logic           d_fail   [NI];
  logic           d_sticky [NI];
  logic [1:0]     d_state  [NI];
  logic [7:0]     c0, c1;
  logic [2:0]     c2;
  logic [31:0]    d_cnt    [NI];
`ifdef FOLLOW_MON_FIRST_FAIL_EN
  logic [7:0]     ff0, ff1;
  logic [2:0]     ff2;
  logic [31:0]    d_ff     [NI];
  assign d_ff[0] = 32'(ff0);
  assign d_ff[1] = 32'(ff1);
  assign d_ff[2] = 32'(ff2);
`endif
  assign d_cnt[0] = 32'(c0);
  assign d_cnt[1] = 32'(c1);
  assign d_cnt[2] = 32'(c2);

  follow_monitor #(.LATENCY(1), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_sig(in_sig), .out_sig(out_v[0]),
    .fail(d_fail[0]), .fail_sticky(d_sticky[0]), .mismatch_cnt(c0), .state(d_state[0])
`ifdef FOLLOW_MON_FIRST_FAIL_EN
    , .first_fail_cyc(ff0)
`endif
  );
  follow_monitor #(.LATENCY(3), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_sig(in_sig), .out_sig(out_v[1]),
    .fail(d_fail[1]), .fail_sticky(d_sticky[1]), .mismatch_cnt(c1), .state(d_state[1])
`ifdef FOLLOW_MON_FIRST_FAIL_EN
    , .first_fail_cyc(ff1)
`endif
  );
  follow_monitor #(.LATENCY(5), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_sig(in_sig), .out_sig(out_v[2]),
    .fail(d_fail[2]), .fail_sticky(d_sticky[2]), .mismatch_cnt(c2), .state(d_state[2])
`ifdef FOLLOW_MON_FIRST_FAIL_EN
    , .first_fail_cyc(ff2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model: hist bit i = in_sig from i+1 enabled cycles ago;
  // ncyc = enabled cycles since history was last discarded.
  bit          m_failed [NI];
  bit          m_fail   [NI];
  int          m_cnt    [NI];
  int          m_ncyc   [NI];
  int          m_ff     [NI];
  logic [31:0] m_hist   [NI];

  function automatic int exp_state(int k);
    if (m_failed[k])               return 3;
    if (m_ncyc[k] == 0)            return 0;
    if (m_ncyc[k] >= lat_of(k))    return 2;
    return 1;
  endfunction

  task automatic model_zero(int k);
    m_failed[k] = 1'b0;
    m_fail[k]   = 1'b0;
    m_cnt[k]    = 0;
    m_ncyc[k]   = 0;
    m_ff[k]     = 0;
    m_hist[k]   = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int  lat  = lat_of(k);
      int  maxc = (1 << w_of(k)) - 1;
      int  st;
      bit  cmp, mism;
      if (!reset) begin
        model_zero(k);
        continue;
      end
      st   = exp_state(k);
      cmp  = (st == 2) || (st == 3 && enable);
      mism = cmp && (out_v[k] != m_hist[k][lat-1]);
      if (clear) begin
        model_zero(k);
        continue;
      end
      m_fail[k] = mism;
      if (mism) begin
        if (m_cnt[k] == 0) m_ff[k] = (m_ncyc[k] > maxc) ? maxc : m_ncyc[k];
        if (m_cnt[k] < maxc) m_cnt[k]++;
        m_failed[k] = 1'b1;
      end
      if (enable) begin
        m_hist[k] = {m_hist[k][30:0], in_sig};
        m_ncyc[k]++;
      end else if (!m_failed[k]) begin
        m_hist[k] = '0;
        m_ncyc[k] = 0;
      end
    end
  endtask

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] @%0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        check("fail",   k, 32'(d_fail[k]),   32'(m_fail[k]));
        check("sticky", k, 32'(d_sticky[k]), 32'(m_failed[k]));
        check("cnt",    k, d_cnt[k],         32'(m_cnt[k]));
        check("state",  k, 32'(d_state[k]),  32'(exp_state(k)));
`ifdef FOLLOW_MON_FIRST_FAIL_EN
        check("first_fail", k, d_ff[k], 32'(m_ff[k]));
`endif
      end
    end
  end

  // out_sig = ideal follower value (random while history is incomplete), flipped where err is set.
  task automatic set_outs(input bit [NI-1:0] err);
    for (int k = 0; k < NI; k++) begin
      int lat = lat_of(k);
      bit t   = (m_ncyc[k] >= lat) ? m_hist[k][lat-1] : 1'($urandom);
      out_v[k] = t ^ err[k];
    end
  endtask

  task automatic cyc(input bit en, input bit clr, input bit i, input bit [NI-1:0] err);
    enable = en;
    clear  = clr;
    in_sig = i;
    set_outs(err);
    @(posedge clk);
    model_step();
    #2;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; in_sig = 1'b0; out_v = '0;
    for (int k = 0; k < NI; k++) model_zero(k);

    cyc(0, 0, 0, '0);
    chk_on = 1'b1;
    cyc(0, 0, 0, '0);
    check("rst_state", 0, 32'(d_state[0]), 0);
    check("rst_cnt",   2, d_cnt[2],        0);
    reset = 1'b1;

    // Ideal follower with toggling input.
    for (int j = 0; j < 20; j++) begin
      cyc(1, 0, 1'(j & 1), '0);
      if (j == 0) begin
        check("t1_state_l1", 0, 32'(d_state[0]), 2);
        check("t1_state_l3", 1, 32'(d_state[1]), 1);
      end
      if (j == 2) check("t1_state_l3b", 1, 32'(d_state[1]), 2);
    end
    check("t1_fail", 0, 32'(d_fail[0]), 0);
    check("t1_cnt",  0, d_cnt[0],       0);

    // Single glitch on u0.
    for (int j = 0; j < 6; j++) begin
      cyc(1, 0, 1'($urandom), (j == 2) ? 3'b001 : 3'b000);
      if (j == 2) begin
        check("t2_fail_pulse", 0, 32'(d_fail[0]), 1);
        check("t2_cnt",        0, d_cnt[0],       1);
      end
      if (j == 3) begin
        check("t2_fail_low", 0, 32'(d_fail[0]),   0);
        check("t2_sticky",   0, 32'(d_sticky[0]), 1);
      end
    end
    cyc(0, 1, 0, '0);
    check("clr_state",  0, 32'(d_state[0]),  0);
    check("clr_sticky", 0, 32'(d_sticky[0]), 0);
    check("clr_cnt",    0, d_cnt[0],         0);

    // Saturation on u2 (CNT_W=3): 12 wrong compares.
    for (int j = 0; j < 17; j++) cyc(1, 0, 1'($urandom), (j >= 5) ? 3'b100 : 3'b000);
    check("t3_sat",    2, d_cnt[2],         7);
    check("t3_sticky", 2, 32'(d_sticky[2]), 1);

    // Clear colliding with a mismatch on u0.
    cyc(0, 1, 0, '0);
    cyc(1, 0, 1'($urandom), '0);
    cyc(1, 0, 1'($urandom), '0);
    cyc(1, 1, 1'($urandom), 3'b001);
    check("t4_state", 0, 32'(d_state[0]), 0);
    check("t4_cnt",   0, d_cnt[0],        0);
    check("t4_fail",  0, 32'(d_fail[0]),  0);

    // LATENCY=3 with a one-cycle enable drop.
    cyc(0, 1, 0, '0);
    for (int j = 0; j < 5; j++) cyc(1, 0, 1'($urandom), '0);
    check("t5_check", 1, 32'(d_state[1]), 2);
    cyc(0, 0, 1'($urandom), '0);
    check("t5_idle", 1, 32'(d_state[1]), 0);
    cyc(1, 0, 1'($urandom), '0);
    check("t5_fill", 1, 32'(d_state[1]), 1);
    cyc(1, 0, 1'($urandom), '0);
    cyc(1, 0, 1'($urandom), '0);
    check("t5_refill", 1, 32'(d_state[1]), 2);
    for (int j = 0; j < 4; j++) cyc(1, 0, 1'($urandom), '0);
    check("t5_nofail", 1, d_cnt[1], 0);

`ifdef FOLLOW_MON_FIRST_FAIL_EN
    // First-fail index: mismatches at enabled cycles 7 and 9.
    cyc(0, 1, 0, '0);
    for (int j = 0; j < 12; j++) cyc(1, 0, 1'($urandom), (j == 7 || j == 9) ? 3'b001 : 3'b000);
    check("t6_first", 0, d_ff[0], 7);
    check("t6_cnt",   0, d_cnt[0], 2);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      bit [NI-1:0] err;
      for (int k = 0; k < NI; k++) err[k] = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 1'($urandom), err);
    end
    reset = 1'b1;
    cyc(0, 0, 0, '0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_follow_monitor
